gs_intt_scheduler: RTL

//   Sequences one full Gentleman-Sande inverse NTT over an N-point polynomial held in a dual-port coefficient RAM.

---
 rtl/ntt_pkg.sv | 21 ++
 rtl/addr_delay_line.sv | 28 ++
 rtl/gs_intt_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and FSM encoding for the NTT control blocks.
package ntt_pkg;

    localparam int COEFF_W     = 30;
    localparam int DEF_LOGN    = 10;
    localparam int DEF_MEM_LAT = 1;
    localparam int DEF_BF_LAT  = 10;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_ISSUE_ENC = 2'd1;
    localparam logic [1:0] ST_DRAIN_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE_ENC,
        S_ISSUE = ST_ISSUE_ENC,
        S_DRAIN = ST_DRAIN_ENC,
        S_DONE  = ST_DONE_ENC
    } sched_state_t;

endpackage

// File: rtl/addr_delay_line.sv
// Fixed-depth shift register carrying {valid, addr_a, addr_b} from the read
// issue point to the write-back point. Cleared on reset so no stale write
// strobe survives an abort.
module addr_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] sr [DEPTH];

    // Shift one slot per cycle; synchronous clear of every slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/gs_intt_scheduler.sv
// Gentleman-Sande inverse NTT address sequencer: one butterfly issued per
// cycle, write-back addresses delayed by the read + butterfly latency.
// Handshake: start is a level sampled only in IDLE; busy covers the cycle
// after acceptance through the done pulse; done is a single-cycle pulse.
module gs_intt_scheduler
    import ntt_pkg::*;
#(
    parameter int LOGN    = DEF_LOGN,
    parameter int MEM_LAT = DEF_MEM_LAT,
    parameter int BF_LAT  = DEF_BF_LAT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [LOGN-1:0] stage,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN-1:0] tw_addr,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b
);

    localparam int              LAT        = MEM_LAT + BF_LAT;
    localparam int              DW         = $clog2(LAT + 1);
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(LAT - 1);
    localparam logic [DW-1:0]   DONE_ONE   = DW'(1);
    localparam logic [LOGN-1:0] ONE        = LOGN'(1);
    localparam logic [LOGN-1:0] H0         = LOGN'(1 << (LOGN - 1));
    localparam logic [LOGN-1:0] LAST_STAGE = LOGN'(LOGN - 1);

    sched_state_t    state;
    logic [LOGN-1:0] d, h, j, k, base;
    logic [DW-1:0]   drain_cnt;

    // Next-butterfly arithmetic: k wraps at d, j steps on wrap, base jumps 2d.
    logic            wrap, last_bf;
    logic [LOGN-1:0] next_j, next_k, next_base, next_a;

    assign wrap      = (k == d - ONE);
    assign last_bf   = wrap && (j == h - ONE);
    assign next_j    = wrap ? j + ONE : j;
    assign next_k    = wrap ? '0 : k + ONE;
    assign next_base = wrap ? base + (d << 1) : base;
    assign next_a    = next_base + next_k;

    // Control FSM with registered issue outputs and stage counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            stage     <= '0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
            d         <= '0;
            h         <= '0;
            j         <= '0;
            k         <= '0;
            base      <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_ISSUE;
                        busy      <= 1'b1;
                        stage     <= '0;
                        d         <= ONE;
                        h         <= H0;
                        j         <= '0;
                        k         <= '0;
                        base      <= '0;
                        rd_en     <= 1'b1;
                        rd_addr_a <= '0;
                        rd_addr_b <= ONE;
                        tw_addr   <= H0;
                    end
                end
                S_ISSUE: begin
                    if (last_bf) begin
                        state     <= S_DRAIN;
                        rd_en     <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        j         <= next_j;
                        k         <= next_k;
                        base      <= next_base;
                        rd_addr_a <= next_a;
                        rd_addr_b <= next_a + d;
                        tw_addr   <= h + next_j;
                    end
                end
                S_DRAIN: begin
                    // Last write of the stage lands in the final drain cycle.
                    if (drain_cnt == DRAIN_LAST) begin
                        if (stage == LAST_STAGE) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_ISSUE;
                            stage     <= stage + ONE;
                            d         <= d << 1;
                            h         <= h >> 1;
                            j         <= '0;
                            k         <= '0;
                            base      <= '0;
                            rd_en     <= 1'b1;
                            rd_addr_a <= '0;
                            rd_addr_b <= d << 1;
                            tw_addr   <= h >> 1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + DONE_ONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    stage <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write-back strobe and addresses follow the issue by LAT cycles.
    addr_delay_line #(
        .W    (2 * LOGN + 1),
        .DEPTH(LAT)
    ) u_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .din  ({rd_en, rd_addr_a, rd_addr_b}),
        .dout ({wr_en, wr_addr_a, wr_addr_b})
    );

endmodule
